// File: rtl/calc_op_sequencer.sv
// Drives one shared W-bit add/sub unit to run calculator ADD/SUB/MUL/DIV.
// MUL is repeated addition and DIV is repeated subtraction; results are registered on entry to DONE.
module calc_op_sequencer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [W-1:0] adder_a,
    output logic [W-1:0] adder_b,
    output logic         adder_ctrl,
    input  logic [W-1:0] adder_sum,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] rem,
    output logic         flag,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]   OP_ADD = 2'b00;
    localparam logic [1:0]   OP_SUB = 2'b01;
    localparam logic [1:0]   OP_MUL = 2'b10;
    localparam logic [1:0]   OP_DIV = 2'b11;
    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] ZERO   = '0;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] quo_q, quo_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] rem_q, rem_d;
    logic         flag_q, flag_d;
    logic         err_q, err_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        rem_d      = rem_q;
        flag_d     = flag_q;
        err_d      = err_q;
        adder_a    = ZERO;
        adder_b    = ZERO;
        adder_ctrl = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = (op == OP_DIV) ? op_a : ZERO;
                    cnt_d   = op_b;
                    quo_d   = ZERO;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // The unit has no carry-out, so carry/borrow come from wrap-around compares.
                case (op_q)
                    OP_ADD: begin
                        adder_a    = a_q;
                        adder_b    = b_q;
                        adder_ctrl = 1'b1;
                        result_d   = adder_sum;
                        rem_d      = ZERO;
                        flag_d     = (adder_sum < a_q);
                        err_d      = 1'b0;
                        state_d    = S_DONE;
                    end
                    OP_SUB: begin
                        adder_a    = a_q;
                        adder_b    = b_q;
                        adder_ctrl = 1'b0;
                        result_d   = adder_sum;
                        rem_d      = ZERO;
                        flag_d     = (adder_sum > a_q);
                        err_d      = 1'b0;
                        state_d    = S_DONE;
                    end
                    OP_MUL: begin
                        adder_a    = acc_q;
                        adder_b    = a_q;
                        adder_ctrl = 1'b1;
                        if (cnt_q == ZERO) begin
                            result_d = acc_q;
                            rem_d    = ZERO;
                            flag_d   = ovf_q;
                            err_d    = 1'b0;
                            state_d  = S_DONE;
                        end else begin
                            acc_d = adder_sum;
                            cnt_d = cnt_q - ONE;
                            ovf_d = ovf_q | (adder_sum < acc_q);
                        end
                    end
                    default: begin
                        adder_a    = acc_q;
                        adder_b    = b_q;
                        adder_ctrl = 1'b0;
                        if (b_q == ZERO) begin
                            result_d = '1;
                            rem_d    = a_q;
                            flag_d   = 1'b0;
                            err_d    = 1'b1;
                            state_d  = S_DONE;
                        end else if (adder_sum > acc_q) begin
                            result_d = quo_q;
                            rem_d    = acc_q;
                            flag_d   = 1'b0;
                            err_d    = 1'b0;
                            state_d  = S_DONE;
                        end else begin
                            acc_d = adder_sum;
                            quo_d = quo_q + ONE;
                        end
                    end
                endcase
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            quo_q    <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rem    = rem_q;
    assign flag   = flag_q;
    assign err    = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed operations with a queue-based scoreboard and
// a behavioural add/sub unit closing the loop around the sequencer.
module tb_calc_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [3:0] op_a, op_b;
    logic [3:0] adder_a, adder_b, adder_sum;
    logic       adder_ctrl;
    logic       busy, done, flag, err;
    logic [3:0] result, rem;

    always #5 clk = ~clk;

    assign adder_sum = adder_ctrl ? (adder_a + adder_b) : (adder_a - adder_b);

    calc_op_sequencer #(.W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .adder_a(adder_a), .adder_b(adder_b), .adder_ctrl(adder_ctrl), .adder_sum(adder_sum),
        .busy(busy), .done(done), .result(result), .rem(rem), .flag(flag), .err(err)
    );

    typedef struct {
        logic [3:0] res;
        logic [3:0] rem;
        logic       flag;
        logic       err;
        int         busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse, checks outputs and RUN length.
    initial begin
        int   bc;
        logic prev_busy;
        exp_t e;
        bc = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy) bc++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_without_request", done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", result, e.res);
                        chk("rem", rem, e.rem);
                        chk("flag", flag, e.flag);
                        chk("err", err, e.err);
                        chk("busy_cycles", bc, e.busy);
                        chk("busy_before_done", prev_busy, 1);
                        chk("busy_at_done", busy, 0);
                    end
                    bc = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic expect_op(input logic [3:0] r, input logic [3:0] m, input logic f,
                             input logic e, input int b);
        exp_t x;
        x.res = r; x.rem = m; x.flag = f; x.err = e; x.busy = b;
        exp_q.push_back(x);
    endtask

    task automatic start_op(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op_a  = 4'($urandom_range(15));
        op_b  = 4'($urandom_range(15));
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("pending_results", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; op_a = 4'd0; op_b = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_rem", rem, 0);
        chk("rst_flag", flag, 0);
        chk("rst_err", err, 0);
        chk("rst_adder_a", adder_a, 0);
        chk("rst_adder_b", adder_b, 0);
        chk("rst_adder_ctrl", adder_ctrl, 1);
        rst = 1'b0;
        @(negedge clk);

        // ADD with carry; adder driven from captured operands during RUN
        expect_op(4'd1, 4'd0, 1'b1, 1'b0, 1);
        start_op(2'b00, 4'd9, 4'd8);
        chk("add_ctrl_run", adder_ctrl, 1);
        chk("add_adder_a", adder_a, 9);
        chk("add_adder_b", adder_b, 8);
        wait_empty();

        expect_op(4'd14, 4'd0, 1'b1, 1'b0, 1);
        start_op(2'b01, 4'd3, 4'd5);
        chk("sub_ctrl_run", adder_ctrl, 0);
        wait_empty();
        expect_op(4'd2, 4'd0, 1'b0, 1'b0, 1);
        start_op(2'b01, 4'd5, 4'd3);
        wait_empty();

        expect_op(4'd12, 4'd0, 1'b0, 1'b0, 5);
        start_op(2'b10, 4'd3, 4'd4);
        wait_empty();
        expect_op(4'd4, 4'd0, 1'b1, 1'b0, 5);
        start_op(2'b10, 4'd5, 4'd4);
        wait_empty();
        expect_op(4'd0, 4'd0, 1'b0, 1'b0, 1);
        start_op(2'b10, 4'd7, 4'd0);
        wait_empty();

        expect_op(4'd3, 4'd1, 1'b0, 1'b0, 4);
        start_op(2'b11, 4'd13, 4'd4);
        wait_empty();
        expect_op(4'd0, 4'd2, 1'b0, 1'b0, 1);
        start_op(2'b11, 4'd2, 4'd5);
        wait_empty();
        expect_op(4'd15, 4'd9, 1'b0, 1'b1, 1);
        start_op(2'b11, 4'd9, 4'd0);
        wait_empty();

        // Second start during RUN must be ignored; rem also clears after the DIV above
        expect_op(4'd14, 4'd0, 1'b1, 1'b0, 6);
        start_op(2'b10, 4'd6, 4'd5);
        repeat (2) @(negedge clk);
        start = 1'b1; op = 2'b11; op_a = 4'd15; op_b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (20) @(negedge clk);

        // Reset in the 4th RUN cycle aborts MUL with no done pulse
        start_op(2'b10, 4'd15, 4'd15);
        repeat (3) @(negedge clk);
        chk("abort_busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_rem", rem, 0);
        chk("abort_flag", flag, 0);
        chk("abort_err", err, 0);
        chk("abort_adder_a", adder_a, 0);
        chk("abort_adder_b", adder_b, 0);
        chk("abort_adder_ctrl", adder_ctrl, 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        expect_op(4'd2, 4'd0, 1'b0, 1'b0, 1);
        start_op(2'b00, 4'd1, 4'd1);
        wait_empty();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
